button_debounce: RTL

- Upstream conditioning stage between the raw Tang Nano 9K push-buttons and the 2-to-4 LED decoder.
- Synchronises each active-low button input to sys_clk and debounces it.
- Presents clean active-low levels, so the decoder can keep its existing active-low input convention.
- Also emits one-cycle press, release and long-press pulses for future sequential consumers (counters, mode FSMs).

---
 rtl/button_debounce_pkg.sv | 21 ++
 rtl/button_debounce_debounce_channel.sv | 94 +++++++++
 rtl/button_debounce.sv | 41 ++++
 3 files changed

// File: rtl/button_debounce_pkg.sv
// Shared constants for the push-button conditioning path: clock rate,
// active-low level encodings and the default debounce / long-press timings.
package button_debounce_pkg;

  localparam int unsigned CLK_HZ = 27000000;

  localparam logic BTN_RELEASED = 1'b1;
  localparam logic BTN_PRESSED  = 1'b0;

  // 10 ms settle time and 1 s hold time at CLK_HZ
  localparam int unsigned DEBOUNCE_CYCLES_DEF = CLK_HZ / 100;
  localparam int unsigned LONG_CYCLES_DEF     = CLK_HZ;

  // Per-channel event bundle for consumers that want all pulses together
  typedef struct packed {
    logic press;
    logic release_evt;
    logic long_press;
  } btn_evt_t;

endpackage : button_debounce_pkg

// File: rtl/button_debounce_debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce counter, long-press timer
// and registered one-cycle press / release / long-press pulses.
module debounce_channel
  import button_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_n_i,
  output logic btn_n_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int unsigned DCW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned LCW = $clog2(LONG_CYCLES);

  logic           sync1_q, sync2_q;
  logic           level_q, level_d;
  logic [DCW-1:0] deb_cnt_q, deb_cnt_d;
  logic [LCW-1:0] long_cnt_q, long_cnt_d;
  logic           long_done_q, long_done_d;
  logic           press_q, press_d;
  logic           release_q, release_d;
  logic           long_q, long_d;

  // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive disagreements
  always_comb begin
    level_d   = level_q;
    deb_cnt_d = deb_cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q == level_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DCW'(DEBOUNCE_CYCLES - 1)) begin
      level_d   = sync2_q;
      deb_cnt_d = '0;
      press_d   = (sync2_q == BTN_PRESSED);
      release_d = (sync2_q == BTN_RELEASED);
    end else begin
      deb_cnt_d = deb_cnt_q + DCW'(1);
    end
  end

  // Long press: counts from the press edge, fires once, then saturates
  always_comb begin
    long_cnt_d  = long_cnt_q;
    long_done_d = long_done_q;
    long_d      = 1'b0;
    if (level_q == BTN_RELEASED || press_d) begin
      long_cnt_d  = '0;
      long_done_d = 1'b0;
    end else if (!long_done_q) begin
      long_cnt_d = long_cnt_q + LCW'(1);
      if (long_cnt_q == LCW'(LONG_CYCLES - 2)) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q     <= BTN_RELEASED;
      sync2_q     <= BTN_RELEASED;
      level_q     <= BTN_RELEASED;
      deb_cnt_q   <= '0;
      long_cnt_q  <= '0;
      long_done_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      sync1_q     <= btn_n_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      deb_cnt_q   <= deb_cnt_d;
      long_cnt_q  <= long_cnt_d;
      long_done_q <= long_done_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  assign btn_n_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule : debounce_channel

// File: rtl/button_debounce.sv
// Conditions N raw active-low push-buttons into clean active-low levels plus
// press / release / long-press pulses; channels are fully independent.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned N               = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic [N-1:0] btn_n_in,
  output logic [N-1:0] btn_n_out,
  output logic [N-1:0] press_pulse,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] long_pulse
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_chan (
      .clk_i    (sys_clk),
      .rst_ni   (sys_rst_n),
      .btn_n_i  (btn_n_in[i]),
      .btn_n_o  (btn_n_out[i]),
      .press_o  (press_pulse[i]),
      .release_o(release_pulse[i]),
      .long_o   (long_pulse[i])
    );
  end

endmodule : button_debounce
